// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise and filter the PS/2 lines, decode 11-bit frames,
// fold E0/F0 prefixes into per-event flags and queue events in a FWFT FIFO.
module ps2_keyboard_rx #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ps2clk,
  input  logic                               ps2data,
  output logic [7:0]                         key_code,
  output logic                               key_break,
  output logic                               key_extended,
  output logic                               key_valid,
  input  logic                               key_ready,
  output logic                               frame_error,
  output logic [1:0]                         error_code,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned EW = 10;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers; both lines idle high.
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2clk};
      dat_sync_q <= {dat_sync_q[0], ps2data};
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples.
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall_q;
  logic          data_q;
  logic          differ;
  logic          flip;

  always_comb begin
    differ = 1'b0;
    flip   = 1'b0;
    differ = (clk_sync_q[1] != filt_q);
    flip   = differ && (fcnt_q == FW'(FILTER_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
      data_q <= 1'b1;
    end else begin
      fall_q <= flip && filt_q;
      data_q <= dat_sync_q[1];
      if (flip) begin
        filt_q <= ~filt_q;
        fcnt_q <= '0;
      end else if (differ) begin
        fcnt_q <= fcnt_q + FW'(1);
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, watchdog and prefix folding.
  state_t        state_q, state_n;
  logic [2:0]    bit_cnt_q, bit_cnt_n;
  logic [7:0]    shift_q, shift_n;
  logic          par_ok_q, par_ok_n;
  logic [TW-1:0] wd_q, wd_n;
  logic          ext_q, ext_n;
  logic          brk_q, brk_n;
  logic          push_q, push_n;
  logic [EW-1:0] push_data_q, push_data_n;
  logic          frame_error_q, frame_error_n;
  logic [1:0]    error_code_q, error_code_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_ok_q      <= 1'b0;
      wd_q          <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
      frame_error_q <= 1'b0;
      error_code_q  <= '0;
    end else begin
      state_q       <= state_n;
      bit_cnt_q     <= bit_cnt_n;
      shift_q       <= shift_n;
      par_ok_q      <= par_ok_n;
      wd_q          <= wd_n;
      ext_q         <= ext_n;
      brk_q         <= brk_n;
      push_q        <= push_n;
      push_data_q   <= push_data_n;
      frame_error_q <= frame_error_n;
      error_code_q  <= error_code_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    bit_cnt_n     = bit_cnt_q;
    shift_n       = shift_q;
    par_ok_n      = par_ok_q;
    ext_n         = ext_q;
    brk_n         = brk_q;
    push_n        = 1'b0;
    push_data_n   = push_data_q;
    frame_error_n = 1'b0;
    error_code_n  = error_code_q;
    wd_n          = (fall_q || (state_q == IDLE)) ? '0 : wd_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (fall_q && !data_q) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_n   = {data_q, shift_q[7:1]};
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_ok_n = ^{shift_q, data_q};
          state_n  = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_n = IDLE;
          if (!data_q || !par_ok_q) begin
            frame_error_n = 1'b1;
            error_code_n  = !data_q ? ERR_STOP : ERR_PARITY;
            ext_n         = 1'b0;
            brk_n         = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_n = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_n = 1'b1;
          end else begin
            push_n      = 1'b1;
            push_data_n = {ext_q, brk_q, shift_q};
            ext_n       = 1'b0;
            brk_n       = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Watchdog abort; only reachable on a cycle without a fall strobe.
    if ((state_q != IDLE) && !fall_q && (wd_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_n       = IDLE;
      frame_error_n = 1'b1;
      error_code_n  = ERR_TIMEOUT;
      ext_n         = 1'b0;
      brk_n         = 1'b0;
      wd_n          = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT event FIFO; the head is registered and holds the last popped entry when empty.
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_n;
  logic [PW-1:0] rd_q, rd_n;
  logic [CW-1:0] count_q, count_n;
  logic [EW-1:0] head_q, head_n;
  logic          valid_q, valid_n;
  logic          ovf_q, ovf_n;
  logic          do_push;
  logic          do_pop;
  logic          full;

  always_comb begin
    do_pop  = valid_q && key_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    do_push = push_q && (!full || do_pop);
    ovf_n   = push_q && full && !do_pop;
    rd_n    = rd_q + PW'(do_pop);
    wr_n    = wr_q + PW'(do_push);
    count_n = count_q + CW'(do_push) - CW'(do_pop);
    valid_n = (count_n != '0);
    head_n  = head_q;
    if (count_n != '0) begin
      if (do_push && (wr_q == rd_n)) begin
        head_n = push_data_q;
      end else begin
        head_n = mem_q[rd_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      count_q <= count_n;
      head_q  <= head_n;
      valid_q <= valid_n;
      ovf_q   <= ovf_n;
    end
  end

  assign key_code     = head_q[7:0];
  assign key_break    = head_q[8];
  assign key_extended = head_q[9];
  assign key_valid    = valid_q;
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign frame_error  = frame_error_q;
  assign error_code   = error_code_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames, prefixes, errors, timeout, FIFO limits, glitch, reset.
module tb_ps2_keyboard_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = 4;
  localparam int unsigned TMO   = 400;
  localparam int unsigned HP    = 20;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2clk = 1'b1;
  logic          ps2data = 1'b1;
  logic          key_ready = 1'b0;
  logic [7:0]    key_code;
  logic          key_break;
  logic          key_extended;
  logic          key_valid;
  logic          frame_error;
  logic [1:0]    error_code;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int err_hi = 0;
  int ovf_hi = 0;

  ps2_keyboard_rx #(
    .FIFO_DEPTH    (DEPTH),
    .FILTER_LEN    (FLEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .key_code    (key_code),
    .key_break   (key_break),
    .key_extended(key_extended),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .frame_error (frame_error),
    .error_code  (error_code),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs; a stuck pulse inflates the count.
  always @(negedge clk) begin
    if (frame_error) err_hi++;
    if (overflow) ovf_hi++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2data = b;
    repeat (HP) @(negedge clk);
    ps2clk = 1'b0;
    repeat (HP) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  // mode 0 plain, 1 latency checks, 2 pop in the push cycle, 3 clock glitch mid-frame
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b,
                            input int mode);
    logic [10:0] bits;
    bit          seen;
    int          n;
    bits = {stop_b, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[i]);
      if (mode == 3 && i == 4) begin
        repeat (5) @(negedge clk);
        ps2clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2clk = 1'b1;
      end
    end
    ps2data = bits[10];
    repeat (HP) @(negedge clk);
    ps2clk = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 3 * HP) begin
      @(negedge clk);
      n++;
      if (dut.fall_q) seen = 1'b1;
    end
    if (mode == 1 || mode == 2) begin
      chk("stop_fall_seen", 32'(seen), 32'd1);
      @(negedge clk);
      if (mode == 1) chk("valid_fall_plus1", 32'(key_valid), 32'd0);
      else key_ready = 1'b1;
      @(negedge clk);
      if (mode == 1) begin
        chk("valid_fall_plus2", 32'(key_valid), 32'd1);
        chk("count_fall_plus2", 32'(fifo_count), 32'd1);
      end else begin
        key_ready = 1'b0;
      end
    end
    repeat (HP) @(negedge clk);
    ps2clk = 1'b1;
    ps2data = 1'b1;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic pop_check(input logic [7:0] code, input logic ext, input logic brk);
    @(negedge clk);
    chk("pop_valid", 32'(key_valid), 32'd1);
    chk("pop_code", 32'(key_code), 32'(code));
    chk("pop_ext", 32'(key_extended), 32'(ext));
    chk("pop_brk", 32'(key_break), 32'(brk));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'h00);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_errcode", 32'(error_code), 32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single make code with latency check.
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    pop_check(8'h1C, 1'b0, 1'b0);

    // Extended break, then plain make.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    chk("prefix_count", 32'(fifo_count), 32'd1);
    pop_check(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    pop_check(8'h75, 1'b0, 1'b0);
    chk("after_pop_count", 32'(fifo_count), 32'd0);

    // Parity error then stop-bit error.
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    chk("par_pulses", 32'(err_hi), 32'd1);
    chk("par_code", 32'(error_code), 32'd1);
    chk("par_count", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    chk("stop_pulses", 32'(err_hi), 32'd2);
    chk("stop_code", 32'(error_code), 32'd2);
    chk("stop_valid", 32'(key_valid), 32'd0);

    // Timeout after start and three data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2data = 1'b1;
    repeat (TMO + 50) @(negedge clk);
    chk("tmo_pulses", 32'(err_hi), 32'd3);
    chk("tmo_code", 32'(error_code), 32'd3);
    chk("tmo_count", 32'(fifo_count), 32'd0);
    send_frame(8'h2A, 1'b0, 1'b1, 0);
    pop_check(8'h2A, 1'b0, 1'b0);

    // Overflow: DEPTH+1 frames with no consumer.
    for (int i = 0; i <= int'(DEPTH); i++) send_frame(8'(8'h11 + i), 1'b0, 1'b1, 0);
    chk("ovf_count", 32'(fifo_count), 32'(DEPTH));
    chk("ovf_pulses", 32'(ovf_hi), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) pop_check(8'(8'h11 + i), 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("drain_valid", 32'(key_valid), 32'd0);
    chk("drain_hold_code", 32'(key_code), 32'h14);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < int'(DEPTH); i++) send_frame(8'(8'h21 + i), 1'b0, 1'b1, 0);
    send_frame(8'h25, 1'b0, 1'b1, 2);
    chk("pp_ovf_pulses", 32'(ovf_hi), 32'd1);
    chk("pp_count", 32'(fifo_count), 32'(DEPTH));
    pop_check(8'h22, 1'b0, 1'b0);
    pop_check(8'h23, 1'b0, 1'b0);
    pop_check(8'h24, 1'b0, 1'b0);
    pop_check(8'h25, 1'b0, 1'b0);

    // Glitch on ps2clk mid-frame must not add a bit.
    send_frame(8'h33, 1'b0, 1'b1, 3);
    @(negedge clk);
    chk("glitch_code", 32'(key_code), 32'h33);
    chk("glitch_count", 32'(fifo_count), 32'd1);
    chk("glitch_pulses", 32'(err_hi), 32'd3);

    // Reset mid-frame with a pending E0 prefix and a queued entry.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(key_valid), 32'd0);
    chk("mrst_code", 32'(key_code), 32'h00);
    chk("mrst_count", 32'(fifo_count), 32'd0);
    chk("mrst_errcode", 32'(error_code), 32'd0);
    repeat (3) @(negedge clk);
    ps2data = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    pop_check(8'h5A, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
